// File: rtl/pi_digit_tx.sv
// pi_digit_tx: streams a captured limb array as an ASCII decimal line.
// Define PI_TX_DECIMAL_POINT_EN to insert '.' after the integer part.
module pi_digit_tx #(
    parameter int WIDTH      = 15,
    parameter int L          = 16,
    parameter int INT_DIGITS = 2,
    parameter int MAX        = 10000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    finish,
    input  logic [L-1:0][WIDTH-1:0] out,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int IW = (L > 1) ? $clog2(L) : 1;
    localparam logic [IW-1:0] LAST  = IW'(L - 1);
    localparam logic [IW-1:0] ILAST = IW'(L - INT_DIGITS);
`ifdef PI_TX_DECIMAL_POINT_EN
    localparam bit DOT_EN = 1'b1;
`else
    localparam bit DOT_EN = 1'b0;
`endif

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] CONV = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] TERM = 3'd4;

    logic [2:0]              state;
    logic                    fin_q;
    logic [L-1:0][WIDTH-1:0] arr;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           nidx;
    logic [WIDTH-1:0]        rem;
    logic [WIDTH-1:0]        nlimb;
    logic [WIDTH-1:0]        wt;
    logic [1:0]              pos;
    logic [3:0][3:0]         dig;
    logic [2:0]              k;
    logic                    bad;
    logic                    nbad;
    logic                    lead;
    logic [3:0]              dk;
    logic                    skip;
    logic                    is_int;
    logic                    emit_dot;
    logic                    free;
    logic [7:0]              ch;

    always_comb begin
        nidx  = (state == LOAD) ? LAST : idx - IW'(1);
        nlimb = arr[nidx];
        nbad  = 32'(nlimb) >= MAX;
        unique case (pos)
            2'd0:    wt = WIDTH'(1000);
            2'd1:    wt = WIDTH'(100);
            default: wt = WIDTH'(10);
        endcase
        dk     = dig[k[1:0]];
        is_int = idx >= ILAST;
        // Keep the final integer digit even when the whole integer part is zero.
        skip   = !bad && is_int && lead && dk == 4'd0 &&
                 !(idx == ILAST && k == 3'd3);
        ch       = bad ? 8'h3F : 8'h30 + {4'h0, dk};
        emit_dot = DOT_EN && idx == ILAST && k == 3'd4;
        free     = !tx_valid || tx_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fin_q    <= 1'b1;
            arr      <= '0;
            idx      <= '0;
            rem      <= '0;
            pos      <= '0;
            dig      <= '0;
            k        <= '0;
            bad      <= 1'b0;
            lead     <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            fin_q <= finish;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (finish && !fin_q) begin
                        arr   <= out;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    err   <= nbad;
                    idx   <= LAST;
                    lead  <= 1'b1;
                    rem   <= nlimb;
                    bad   <= nbad;
                    pos   <= '0;
                    dig   <= '0;
                    state <= CONV;
                end
                CONV: begin
                    if (bad) begin
                        k     <= '0;
                        state <= SEND;
                    end else if (rem >= wt) begin
                        rem      <= rem - wt;
                        dig[pos] <= dig[pos] + 4'd1;
                    end else if (pos == 2'd2) begin
                        dig[3] <= rem[3:0];
                        k      <= '0;
                        state  <= SEND;
                    end else begin
                        pos <= pos + 2'd1;
                    end
                end
                SEND: begin
                    if (free) begin
                        if (k < 3'd4) begin
                            k <= k + 3'd1;
                            if (skip) begin
                                tx_valid <= 1'b0;
                            end else begin
                                tx_data  <= ch;
                                tx_valid <= 1'b1;
                                lead     <= 1'b0;
                            end
                        end else if (emit_dot) begin
                            tx_data  <= 8'h2E;
                            tx_valid <= 1'b1;
                            k        <= 3'd5;
                        end else begin
                            tx_valid <= 1'b0;
                            if (idx == '0) begin
                                state <= TERM;
                            end else begin
                                idx   <= nidx;
                                rem   <= nlimb;
                                bad   <= nbad;
                                pos   <= '0;
                                dig   <= '0;
                                state <= CONV;
                                if (nbad) err <= 1'b1;
                            end
                        end
                    end
                end
                TERM: begin
                    if (!tx_valid) begin
                        tx_data  <= 8'h0A;
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
